// File: rtl/data_mem_store_rmw.sv
// Store-path writer over a word-only memory port: word stores write directly, byte/half stores read-modify-write.
// Optional feature: define STORE_MISALIGN_TRAP_EN to drop misaligned half/word stores with st_err_o instead of truncating.
module data_mem_store_rmw #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [ADDR_WIDTH-1:0] st_addr_i,
    input  logic [ADDR_WIDTH-1:0] st_data_i,
    input  logic [1:0]            mem_type_i,
    output logic                  st_done_o,
    output logic                  st_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [ADDR_WIDTH-1:0] mem_wdata_o,
    input  logic [ADDR_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            off_q, off_d;
    logic [15:0]           data_q, data_d;
    logic [1:0]            type_q, type_d;
    logic [ADDR_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [ADDR_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_sub_word_s;

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] data,
                                               input logic [1:0] off, input logic [1:0] mtype);
        logic [31:0] m;
        m = word;
        case (mtype)
            2'b01: begin
                case (off)
                    2'b00:   m[7:0]   = data[7:0];
                    2'b01:   m[15:8]  = data[7:0];
                    2'b10:   m[23:16] = data[7:0];
                    2'b11:   m[31:24] = data[7:0];
                    default: m        = word;
                endcase
            end
            2'b10: begin
                if (off[1]) begin
                    m[31:16] = data;
                end else begin
                    m[15:0] = data;
                end
            end
            default: m = word;
        endcase
        return m;
    endfunction

    assign is_sub_word_s = (mem_type_i == 2'b01) || (mem_type_i == 2'b10);

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        data_d  = data_q;
        type_d  = type_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (st_valid_i) begin
                    off_d   = st_addr_i[1:0];
                    data_d  = st_data_i[15:0];
                    type_d  = mem_type_i;
                    maddr_d = {st_addr_i[ADDR_WIDTH-1:2], 2'b00};
`ifdef STORE_MISALIGN_TRAP_EN
                    if (((mem_type_i == 2'b10) && st_addr_i[0]) ||
                        (!is_sub_word_s && (st_addr_i[1:0] != 2'b00))) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        maddr_d = maddr_q;
                    end else
`endif
                    if (is_sub_word_s) begin
                        state_d = S_READ;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                    end else begin
                        state_d = S_WRITE;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        wdata_d = st_data_i;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (mem_ack_i) begin
                    rdata_d = mem_rdata_i;
                    req_d   = 1'b0;
                    state_d = S_MERGE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_MERGE: begin
                wdata_d = merge_lane(rdata_q, data_q, off_q, type_q);
                req_d   = 1'b1;
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset abandons any in-flight store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            off_q   <= 2'b00;
            data_q  <= 16'h0000;
            type_q  <= 2'b00;
            rdata_q <= {ADDR_WIDTH{1'b0}};
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            data_q  <= data_d;
            type_q  <= type_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign st_ready_o  = ready_q;
    assign st_done_o   = done_q;
    assign st_err_o    = err_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_data_mem_store_rmw.sv
// Directed table-driven bench for data_mem_store_rmw; the bench acts as the memory and checks each store.
module tb_data_mem_store_rmw;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  mem_type;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    data_mem_store_rmw #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid_i (st_valid),
        .st_ready_o (st_ready),
        .st_addr_i  (st_addr),
        .st_data_i  (st_data),
        .mem_type_i (mem_type),
        .st_done_o  (st_done),
        .st_err_o   (st_err),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .mem_ack_i  (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  mtype;
        logic [31:0] mem_word;
        int          wait_n;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one store and plays memory; returns what was observed.
    task automatic run_store(input vec_t v, output int lat, output int nr, output int nw,
                             output logic [31:0] wa, output logic [31:0] wd, output logic [31:0] ra,
                             output logic er, output bit stab, output bit busy_ok, output bit pulse_ok);
        bit          prev_req;
        int          waitcnt;
        logic [31:0] ref_addr, ref_wdata;
        logic        ref_we;
        lat = -1; nr = 0; nw = 0; wa = 32'h0; wd = 32'h0; ra = 32'h0; er = 1'b0;
        stab = 1'b1; busy_ok = 1'b1; pulse_ok = 1'b0;
        prev_req = 1'b0; waitcnt = 0;
        ref_addr = 32'h0; ref_wdata = 32'h0; ref_we = 1'b0;
        @(negedge clk);
        if (!st_ready) busy_ok = 1'b0;
        st_valid = 1'b1; st_addr = v.addr; st_data = v.data; mem_type = v.mtype;
        @(negedge clk);
        st_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
            if (st_done) begin
                lat = k;
                er  = st_err;
                break;
            end
            if (st_ready) busy_ok = 1'b0;
            if (mem_req) begin
                if (!prev_req) begin
                    ref_addr = mem_addr; ref_we = mem_we; ref_wdata = mem_wdata; waitcnt = 0;
                end else if (mem_addr !== ref_addr || mem_we !== ref_we ||
                             (mem_we && mem_wdata !== ref_wdata)) begin
                    stab = 1'b0;
                end
                if (waitcnt >= v.wait_n) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        nw++; wa = mem_addr; wd = mem_wdata;
                    end else begin
                        nr++; ra = mem_addr; mem_rdata = v.mem_word;
                    end
                end else begin
                    waitcnt++;
                end
            end
            prev_req = mem_req && !mem_ack;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        pulse_ok = !st_done && st_ready && !mem_req;
    endtask

    task automatic check_store(input vec_t v);
        int          lat, nr, nw;
        logic [31:0] wa, wd, ra;
        logic        er;
        bit          stab, busy_ok, pulse_ok;
        run_store(v, lat, nr, nw, wa, wd, ra, er, stab, busy_ok, pulse_ok);
        chk({v.name, " latency"}, lat, v.exp_lat);
        chk({v.name, " reads"}, nr, v.exp_reads);
        chk({v.name, " writes"}, nw, v.exp_writes);
        chk({v.name, " err"}, {31'h0, er}, {31'h0, v.exp_err});
        chk({v.name, " ready_low_busy"}, {31'h0, busy_ok}, 32'h1);
        chk({v.name, " done_pulse"}, {31'h0, pulse_ok}, 32'h1);
        if (v.exp_writes > 0) begin
            chk({v.name, " waddr"}, wa, v.exp_waddr);
            chk({v.name, " wdata"}, wd, v.exp_wdata);
            chk({v.name, " stable"}, {31'h0, stab}, 32'h1);
        end
        if (v.exp_reads > 0) begin
            chk({v.name, " raddr"}, ra, v.exp_waddr);
        end
    endtask

    vec_t vecs[12];

    initial begin
        bit ok;
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; mem_type = 2'b00;
        mem_rdata = 32'hBAD0BAD0; mem_ack = 1'b0;
        rst = 1'b1;

        //            name         addr          data          type   mem_word      wt lat r  w  waddr         wdata         err
        vecs[0]  = '{"word",      32'h00000100, 32'hDEADBEEF, 2'b00, 32'h00000000, 0, 2,  0, 1, 32'h00000100, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{"byte3",     32'h00000203, 32'h000000AA, 2'b01, 32'h11223344, 0, 4,  1, 1, 32'h00000200, 32'hAA223344, 1'b0};
        vecs[2]  = '{"half_hi",   32'h00000302, 32'h0000BEEF, 2'b10, 32'h11223344, 0, 4,  1, 1, 32'h00000300, 32'hBEEF3344, 1'b0};
        vecs[3]  = '{"half_lo",   32'h00000300, 32'h0000BEEF, 2'b10, 32'h11223344, 0, 4,  1, 1, 32'h00000300, 32'h1122BEEF, 1'b0};
        vecs[4]  = '{"byte0",     32'h00000200, 32'hFFFFFF55, 2'b01, 32'h11223344, 0, 4,  1, 1, 32'h00000200, 32'h11223355, 1'b0};
        vecs[5]  = '{"byte1",     32'h00000201, 32'h00000066, 2'b01, 32'h11223344, 0, 4,  1, 1, 32'h00000200, 32'h11226644, 1'b0};
        vecs[6]  = '{"byte2",     32'h00000202, 32'h00000077, 2'b01, 32'h11223344, 0, 4,  1, 1, 32'h00000200, 32'h11773344, 1'b0};
        vecs[7]  = '{"word11",    32'h00000010, 32'h12345678, 2'b11, 32'h00000000, 0, 2,  0, 1, 32'h00000010, 32'h12345678, 1'b0};
        vecs[8]  = '{"byte_wait", 32'h00000203, 32'h000000AA, 2'b01, 32'h11223344, 3, 10, 1, 1, 32'h00000200, 32'hAA223344, 1'b0};
        vecs[9]  = '{"word_wait", 32'h00000500, 32'hA5A55A5A, 2'b00, 32'h00000000, 3, 5,  0, 1, 32'h00000500, 32'hA5A55A5A, 1'b0};
`ifdef STORE_MISALIGN_TRAP_EN
        vecs[10] = '{"word_mis",  32'h00000107, 32'hCAFEF00D, 2'b00, 32'h00000000, 0, 1,  0, 0, 32'h00000000, 32'h00000000, 1'b1};
        vecs[11] = '{"half_mis",  32'h00000401, 32'h0000BEEF, 2'b10, 32'hAABBCCDD, 0, 1,  0, 0, 32'h00000000, 32'h00000000, 1'b1};
`else
        vecs[10] = '{"word_mis",  32'h00000107, 32'hCAFEF00D, 2'b00, 32'h00000000, 0, 2,  0, 1, 32'h00000104, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{"half_mis",  32'h00000401, 32'h0000BEEF, 2'b10, 32'hAABBCCDD, 0, 4,  1, 1, 32'h00000400, 32'hAABBBEEF, 1'b0};
`endif

        repeat (2) @(negedge clk);
        chk("rst ready", {31'h0, st_ready}, 32'h1);
        chk("rst req", {31'h0, mem_req}, 32'h0);
        chk("rst we", {31'h0, mem_we}, 32'h0);
        chk("rst done", {31'h0, st_done}, 32'h0);
        chk("rst err", {31'h0, st_err}, 32'h0);
        chk("rst addr", mem_addr, 32'h0);
        chk("rst wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // Ack while idle must not start anything.
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            if (mem_req || st_done || !st_ready) ok = 1'b0;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (mem_req || st_done || !st_ready) ok = 1'b0;
        chk("idle_ack_ignored", {31'h0, ok}, 32'h1);

        for (int i = 0; i < 12; i++) begin
            check_store(vecs[i]);
        end

        // Reset while READ is waiting for ack.
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h00000203; st_data = 32'h000000AA; mem_type = 2'b01;
        @(negedge clk);
        st_valid = 1'b0;
        chk("midrst req_before", {31'h0, mem_req}, 32'h1);
        chk("midrst we_before", {31'h0, mem_we}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("midrst req_dropped", {31'h0, mem_req}, 32'h0);
        chk("midrst ready", {31'h0, st_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (st_done || mem_req) ok = 1'b0;
        end
        chk("midrst no_done", {31'h0, ok}, 32'h1);
        begin
            vec_t v;
            v = '{"after_rst", 32'h00000001, 32'h00000099, 2'b01, 32'h55667788, 0, 4, 1, 1,
                  32'h00000000, 32'h55669988, 1'b0};
            check_store(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
